// File: rtl/lcd_ctrl_pkg.sv
// Shared types for the parametrised LCD image-buffer controller:
// host command codes and controller FSM states.
package lcd_ctrl_pkg;

   typedef enum logic [3:0] {
      CMD_WRITE    = 4'd0,
      CMD_UP       = 4'd1,
      CMD_DOWN     = 4'd2,
      CMD_LEFT     = 4'd3,
      CMD_RIGHT    = 4'd4,
      CMD_MAX      = 4'd5,
      CMD_MIN      = 4'd6,
      CMD_AVG      = 4'd7,
      CMD_ROT_CCW  = 4'd8,
      CMD_ROT_CW   = 4'd9,
      CMD_MIRROR_X = 4'd10,
      CMD_MIRROR_Y = 4'd11,
      CMD_BRIGHTEN = 4'd12,
      CMD_DARKEN   = 4'd13,
      CMD_RECENTRE = 4'd14,
      CMD_NOP      = 4'd15
   } cmd_e;

   typedef enum logic [2:0] {
      StIdle,
      StLoad,
      StWaitCmd,
      StExec,
      StWrite,
      StFin
   } state_e;

endpackage

// File: rtl/lcd_win_alu.sv
// Combinational 2x2 window operator: given the four window pixels and a command,
// produces the four replacement pixels (pass-through for non-pixel commands).
module lcd_win_alu
   import lcd_ctrl_pkg::*;
#(
   parameter int unsigned PIX_W       = 8,
   parameter int unsigned BRIGHT_STEP = 16
) (
   input  cmd_e             cmd_i,
   input  logic [PIX_W-1:0] p0_i,
   input  logic [PIX_W-1:0] p1_i,
   input  logic [PIX_W-1:0] p2_i,
   input  logic [PIX_W-1:0] p3_i,
   output logic [PIX_W-1:0] n0_o,
   output logic [PIX_W-1:0] n1_o,
   output logic [PIX_W-1:0] n2_o,
   output logic [PIX_W-1:0] n3_o
);

   localparam logic [PIX_W-1:0] PixMax = '1;
   localparam logic [PIX_W-1:0] Step   = PIX_W'(BRIGHT_STEP);

   logic [PIX_W-1:0] max01, max23, max_all;
   logic [PIX_W-1:0] min01, min23, min_all;
   logic [PIX_W+1:0] sum;
   logic [PIX_W-1:0] avg;

   function automatic logic [PIX_W-1:0] brighten(input logic [PIX_W-1:0] p);
      logic [PIX_W:0] s;
      s = {1'b0, p} + {1'b0, Step};
      return s[PIX_W] ? PixMax : s[PIX_W-1:0];
   endfunction

   function automatic logic [PIX_W-1:0] darken(input logic [PIX_W-1:0] p);
      return (p < Step) ? '0 : (p - Step);
   endfunction

   always_comb begin
      max01   = (p0_i > p1_i) ? p0_i : p1_i;
      max23   = (p2_i > p3_i) ? p2_i : p3_i;
      max_all = (max01 > max23) ? max01 : max23;
      min01   = (p0_i < p1_i) ? p0_i : p1_i;
      min23   = (p2_i < p3_i) ? p2_i : p3_i;
      min_all = (min01 < min23) ? min01 : min23;
      sum     = {2'b00, p0_i} + {2'b00, p1_i} + {2'b00, p2_i} + {2'b00, p3_i};
      avg     = sum[PIX_W+1:2];
   end

   always_comb begin
      n0_o = p0_i;
      n1_o = p1_i;
      n2_o = p2_i;
      n3_o = p3_i;
      case (cmd_i)
         CMD_MAX: begin
            n0_o = max_all; n1_o = max_all; n2_o = max_all; n3_o = max_all;
         end
         CMD_MIN: begin
            n0_o = min_all; n1_o = min_all; n2_o = min_all; n3_o = min_all;
         end
         CMD_AVG: begin
            n0_o = avg; n1_o = avg; n2_o = avg; n3_o = avg;
         end
         CMD_ROT_CCW: begin
            n0_o = p1_i; n1_o = p3_i; n2_o = p0_i; n3_o = p2_i;
         end
         CMD_ROT_CW: begin
            n0_o = p2_i; n1_o = p0_i; n2_o = p3_i; n3_o = p1_i;
         end
         CMD_MIRROR_X: begin
            n0_o = p2_i; n1_o = p3_i; n2_o = p0_i; n3_o = p1_i;
         end
         CMD_MIRROR_Y: begin
            n0_o = p1_i; n1_o = p0_i; n2_o = p3_i; n3_o = p2_i;
         end
         CMD_BRIGHTEN: begin
            n0_o = brighten(p0_i); n1_o = brighten(p1_i);
            n2_o = brighten(p2_i); n3_o = brighten(p3_i);
         end
         CMD_DARKEN: begin
            n0_o = darken(p0_i); n1_o = darken(p1_i);
            n2_o = darken(p2_i); n3_o = darken(p3_i);
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/lcd_ctrl_param.sv
// Parametrised LCD image-buffer controller: loads a frame from IROM, applies host
// window commands around an operation point, and streams the frame to IRAM.
module lcd_ctrl_param
   import lcd_ctrl_pkg::*;
#(
   parameter int unsigned W_LOG2      = 3,
   parameter int unsigned H_LOG2      = 3,
   parameter int unsigned PIX_W       = 8,
   parameter int unsigned BRIGHT_STEP = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [3:0]               cmd,
   input  logic                     cmd_valid,
   input  logic [PIX_W-1:0]         IROM_Q,
   output logic                     IROM_rd,
   output logic [W_LOG2+H_LOG2-1:0] IROM_A,
   output logic                     IRAM_valid,
   output logic [PIX_W-1:0]         IRAM_D,
   output logic [W_LOG2+H_LOG2-1:0] IRAM_A,
   output logic                     busy,
   output logic                     done
);

   localparam int unsigned AW = W_LOG2 + H_LOG2;
   localparam int unsigned N  = 1 << AW;

   localparam logic [AW-1:0]     AddrLast = '1;
   localparam logic [W_LOG2-1:0] XMin     = W_LOG2'(1);
   localparam logic [W_LOG2-1:0] XMax     = '1;
   localparam logic [W_LOG2-1:0] XMid     = W_LOG2'(1 << (W_LOG2 - 1));
   localparam logic [H_LOG2-1:0] YMin     = H_LOG2'(1);
   localparam logic [H_LOG2-1:0] YMax     = '1;
   localparam logic [H_LOG2-1:0] YMid     = H_LOG2'(1 << (H_LOG2 - 1));

   state_e            state_q, state_d;
   cmd_e              cmd_q, cmd_d;
   logic [AW-1:0]     addr_q, addr_d;
   logic [W_LOG2-1:0] x_q, x_d;
   logic [H_LOG2-1:0] y_q, y_d;
   logic [PIX_W-1:0]  pix_q [N];
   logic [PIX_W-1:0]  pix_d [N];

   logic [W_LOG2-1:0] xm1;
   logic [H_LOG2-1:0] ym1;
   logic [AW-1:0]     a0, a1, a2, a3;
   logic [PIX_W-1:0]  n0, n1, n2, n3;

   // Window addresses are {row, col}, matching the IROM/IRAM address layout.
   always_comb begin
      xm1 = x_q - 1'b1;
      ym1 = y_q - 1'b1;
      a0  = {ym1, xm1};
      a1  = {ym1, x_q};
      a2  = {y_q, xm1};
      a3  = {y_q, x_q};
   end

   lcd_win_alu #(
      .PIX_W       (PIX_W),
      .BRIGHT_STEP (BRIGHT_STEP)
   ) u_win_alu (
      .cmd_i (cmd_q),
      .p0_i  (pix_q[a0]),
      .p1_i  (pix_q[a1]),
      .p2_i  (pix_q[a2]),
      .p3_i  (pix_q[a3]),
      .n0_o  (n0),
      .n1_o  (n1),
      .n2_o  (n2),
      .n3_o  (n3)
   );

   always_comb begin
      state_d = state_q;
      cmd_d   = cmd_q;
      addr_d  = addr_q;
      x_d     = x_q;
      y_d     = y_q;
      pix_d   = pix_q;
      unique case (state_q)
         StIdle: begin
            addr_d  = '0;
            state_d = StLoad;
         end
         StLoad: begin
            pix_d[addr_q] = IROM_Q;
            addr_d        = addr_q + 1'b1;
            if (addr_q == AddrLast) state_d = StWaitCmd;
         end
         StWaitCmd: begin
            if (cmd_valid) begin
               cmd_d   = cmd_e'(cmd);
               addr_d  = '0;
               state_d = (cmd_e'(cmd) == CMD_WRITE) ? StWrite : StExec;
            end
         end
         StExec: begin
            // Pixel commands rewrite the window; the ALU passes others through unchanged.
            pix_d[a0] = n0;
            pix_d[a1] = n1;
            pix_d[a2] = n2;
            pix_d[a3] = n3;
            case (cmd_q)
               CMD_UP:       if (y_q != YMin) y_d = y_q - 1'b1;
               CMD_DOWN:     if (y_q != YMax) y_d = y_q + 1'b1;
               CMD_LEFT:     if (x_q != XMin) x_d = x_q - 1'b1;
               CMD_RIGHT:    if (x_q != XMax) x_d = x_q + 1'b1;
               CMD_RECENTRE: begin
                  x_d = XMid;
                  y_d = YMid;
               end
               default: ;
            endcase
            state_d = StWaitCmd;
         end
         StWrite: begin
            addr_d = addr_q + 1'b1;
            if (addr_q == AddrLast) state_d = StFin;
         end
         StFin: begin
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= StIdle;
         cmd_q   <= CMD_NOP;
         addr_q  <= '0;
         x_q     <= XMid;
         y_q     <= YMid;
         pix_q   <= '{default: '0};
      end else begin
         state_q <= state_d;
         cmd_q   <= cmd_d;
         addr_q  <= addr_d;
         x_q     <= x_d;
         y_q     <= y_d;
         pix_q   <= pix_d;
      end
   end

   always_comb begin
      IROM_rd    = (state_q == StLoad);
      IROM_A     = IROM_rd ? addr_q : '0;
      IRAM_valid = (state_q == StWrite);
      IRAM_A     = IRAM_valid ? addr_q : '0;
      IRAM_D     = IRAM_valid ? pix_q[addr_q] : '0;
      busy       = (state_q != StWaitCmd);
      done       = (state_q == StFin);
   end

endmodule
